// File: rtl/spi_master_ctrl.sv
// SPI master: one 1..DATA_W bit frame per start; CPOL/CPHA, bit order, length and SCK rate latched per frame.
// Define SPI_MASTER_LOOPBACK_EN to add loop_en, which samples the internal mosi instead of phy_miso.
module spi_master_ctrl #(
    parameter int DATA_W  = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic [4:0]         bit_count,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic               conf_cpol,
    input  logic               conf_cpha,
    input  logic               conf_dir,
    input  logic               err_clr,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic               loop_en,
`endif
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  rx_data,
    output logic [2:0]         err,
    output logic               phy_sck,
    output logic               phy_mosi,
    input  logic               phy_miso,
    output logic               phy_cs
);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;
    localparam logic [5:0] MAX_N = 6'(DATA_W);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d, presc_q, presc_d;
    logic [6:0]         sck_edge_q, sck_edge_d, sck_edge_nxt;
    logic [5:0]         n_q, n_d, n_in;
    logic               cpol_q, cpol_d, cpha_q, cpha_d, dir_q, dir_d;
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d, tx_shifted, tx_load;
    logic [DATA_W-1:0]  rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic               sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [2:0]         err_q, err_d;
    logic               can_start, start_ok, tick, last_edge, miso_bit;

    function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb_first);
        return lsb_first ? v[0] : v[DATA_W-1];
    endfunction

    // Oversized counts are clamped; MSB-first words are pre-aligned so the first bit sits at the top.
    assign n_in    = ({1'b0, bit_count} > MAX_N) ? MAX_N : {1'b0, bit_count};
    assign tx_load = conf_dir ? tx_data : (tx_data << (MAX_N - n_in));

`ifdef SPI_MASTER_LOOPBACK_EN
    logic loop_q, loop_d;
    assign miso_bit = loop_q ? mosi_q : phy_miso;
`else
    assign miso_bit = phy_miso;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        sck_edge_d = sck_edge_q;
        n_d        = n_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        dir_d      = dir_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        err_d      = err_clr ? 3'b000 : err_q;
`ifdef SPI_MASTER_LOOPBACK_EN
        loop_d     = loop_q;
`endif
        sck_edge_nxt = sck_edge_q + 7'd1;
        last_edge    = (sck_edge_nxt == {n_q, 1'b0});
        tx_shifted   = dir_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
        tick         = (cnt_q == '0);
        can_start    = (state_q == IDLE) || (state_q == DONE);
        start_ok     = start && can_start && (bit_count != 5'd0) && (prescaler >= PRESC_W'(2));

        if (start) begin
            if (!can_start)             err_d[0] = 1'b1;
            if (bit_count == 5'd0)      err_d[1] = 1'b1;
            if (prescaler < PRESC_W'(2)) err_d[2] = 1'b1;
        end

        case (state_q)
            LEAD, SHIFT: begin
                cnt_d = cnt_q - PRESC_W'(1);
                if (tick) begin
                    cnt_d      = presc_q - PRESC_W'(1);
                    sck_edge_d = sck_edge_nxt;
                    sck_d      = ~sck_q;
                    if (sck_edge_nxt[0] ^ cpha_q) begin
                        rx_sh_d = dir_q ? {miso_bit, rx_sh_q[DATA_W-1:1]}
                                        : {rx_sh_q[DATA_W-2:0], miso_bit};
                    end else if (cpha_q) begin
                        mosi_d  = head_bit(tx_sh_q, dir_q);
                        tx_sh_d = tx_shifted;
                    end else if (!last_edge) begin
                        tx_sh_d = tx_shifted;
                        mosi_d  = head_bit(tx_shifted, dir_q);
                    end
                    state_d = last_edge ? TRAIL : SHIFT;
                end
            end
            TRAIL: begin
                cnt_d = cnt_q - PRESC_W'(1);
                if (tick) begin
                    state_d   = DONE;
                    rx_data_d = dir_q ? (rx_sh_q >> (MAX_N - n_q)) : rx_sh_q;
                end
            end
            DONE:    state_d = IDLE;
            default: sck_d = conf_cpol;
        endcase

        if (start_ok) begin
            state_d    = LEAD;
            cnt_d      = prescaler - PRESC_W'(1);
            presc_d    = prescaler;
            sck_edge_d = '0;
            n_d        = n_in;
            cpol_d     = conf_cpol;
            cpha_d     = conf_cpha;
            dir_d      = conf_dir;
            tx_sh_d    = tx_load;
            rx_sh_d    = '0;
            sck_d      = conf_cpol;
            mosi_d     = head_bit(tx_load, conf_dir);
`ifdef SPI_MASTER_LOOPBACK_EN
            loop_d     = loop_en;
`endif
        end

        busy_d = (state_d == LEAD) || (state_d == SHIFT) || (state_d == TRAIL);
        cs_d   = ~busy_d;
        done_d = (state_d == DONE);
        if (!busy_d) mosi_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q   <= IDLE;
            sck_q     <= conf_cpol;
            mosi_q    <= 1'b1;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            err_q     <= err_d;
        end
    end

    // Frame datapath is reloaded on every accepted start, so it carries no reset.
    always_ff @(posedge clk_i) begin
        cnt_q      <= cnt_d;
        presc_q    <= presc_d;
        sck_edge_q <= sck_edge_d;
        n_q        <= n_d;
        cpol_q     <= cpol_d;
        cpha_q     <= cpha_d;
        dir_q      <= dir_d;
        tx_sh_q    <= tx_sh_d;
        rx_sh_q    <= rx_sh_d;
`ifdef SPI_MASTER_LOOPBACK_EN
        loop_q     <= loop_d;
`endif
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign err      = err_q;
    assign phy_sck  = sck_q;
    assign phy_mosi = mosi_q;
    assign phy_cs   = cs_q;

endmodule
